math_round_ctrl: RTL and testbench

- Parametrised round controller for the sum-to-target math game.
- Generalises the single-player "random number plus player entry equals 15" flow to NUM_PLAYERS competing players with a configurable target and round length.
- Owns the game state machine, the per-player scores, per-number lockout, and the round countdown in seconds.
- Sits between the access controller (enable), the random generator (rand_req/rand_val), the one-second timer (sec_tick) and the seven-segment display decoders.

---
 rtl/math_round_ctrl_if.sv | 40 ++++
 rtl/math_round_ctrl.sv | 169 ++++++++++++++++
 tb/tb_math_round_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/math_round_ctrl_if.sv
// rtl/math_round_ctrl_if.sv - handshake/bus bundle between the round controller and its surroundings
// Purpose: groups the game-facing signals of math_round_ctrl.
// master : controller side (drives rand_req, cur_val, scores, time_left, hit, miss,
//          last_player, lockout, round_over, winner, tie)
// slave  : environment side (drives enable, start, sec_tick, rand_val, load, guess)
interface math_round_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int DATA_W      = 4,
    parameter int SCORE_W     = 7
);
    logic                           enable;
    logic                           start;
    logic                           sec_tick;
    logic [DATA_W-1:0]              rand_val;
    logic                           rand_req;
    logic [NUM_PLAYERS-1:0]         load;
    logic [NUM_PLAYERS*DATA_W-1:0]  guess;
    logic [DATA_W-1:0]              cur_val;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic [6:0]                     time_left;
    logic                           hit;
    logic                           miss;
    logic [2:0]                     last_player;
    logic [NUM_PLAYERS-1:0]         lockout;
    logic                           round_over;
    logic [2:0]                     winner;
    logic                           tie;

    modport master (
        input  enable, start, sec_tick, rand_val, load, guess,
        output rand_req, cur_val, scores, time_left, hit, miss,
               last_player, lockout, round_over, winner, tie
    );

    modport slave (
        output enable, start, sec_tick, rand_val, load, guess,
        input  rand_req, cur_val, scores, time_left, hit, miss,
               last_player, lockout, round_over, winner, tie
    );
endinterface

// File: rtl/math_round_ctrl.sv
// rtl/math_round_ctrl.sv - multi-player sum-to-target round controller
// Purpose: runs a timed round in which players race to submit guess such that
//          cur_val + guess == TARGET; keeps scores, per-number lockout and countdown.
// Ports: clk, rst (async, active-high); bus (math_round_ctrl_if.master) carrying
//        enable/start/sec_tick/rand_val/load/guess in and rand_req/cur_val/scores/
//        time_left/hit/miss/last_player/lockout/round_over/winner/tie out.
module math_round_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int DATA_W      = 4,
    parameter int TARGET      = 15,
    parameter int ROUND_SECS  = 30,
    parameter int SCORE_W     = 7,
    parameter int SCORE_MAX   = 99
) (
    input  logic               clk,
    input  logic               rst,
    math_round_ctrl_if.master  bus
);
    localparam logic [DATA_W:0]  LP_TARGET = (DATA_W+1)'(TARGET);
    localparam logic [SCORE_W-1:0] LP_SMAX = SCORE_W'(SCORE_MAX);
    localparam logic [6:0]       LP_SECS   = 7'(ROUND_SECS);

    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_FETCH, S_PLAY, S_DONE} state_t;

    state_t                         r_state, w_state_nxt;
    logic [DATA_W-1:0]              r_cur_val, w_cur_val_nxt;
    logic [NUM_PLAYERS*SCORE_W-1:0] r_scores, w_scores_nxt;
    logic [6:0]                     r_time_left, w_time_left_nxt;
    logic                           r_hit, w_hit_nxt;
    logic                           r_miss, w_miss_nxt;
    logic [2:0]                     r_last_player, w_last_player_nxt;
    logic [NUM_PLAYERS-1:0]         r_lockout, w_lockout_nxt;

    logic [NUM_PLAYERS-1:0]         w_cand;
    logic                           w_any;
    logic [2:0]                     w_sel;
    logic [DATA_W-1:0]              w_sel_guess;
    logic [DATA_W:0]                w_sum;
    logic                           w_is_hit;
    logic [SCORE_W-1:0]             w_max;
    logic [2:0]                     w_win;
    logic [3:0]                     w_top_cnt;

    // Lowest-index unlocked submitter wins the cycle; the sum is one bit wider so it never wraps.
    always_comb begin
        w_cand      = bus.load & ~r_lockout;
        w_any       = |w_cand;
        w_sel       = '0;
        w_sel_guess = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel       = 3'(i);
                w_sel_guess = bus.guess[i*DATA_W +: DATA_W];
            end
        end
        w_sum    = {1'b0, r_cur_val} + {1'b0, w_sel_guess};
        w_is_hit = (w_sum == LP_TARGET);
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cur_val_nxt     = r_cur_val;
        w_scores_nxt      = r_scores;
        w_time_left_nxt   = r_time_left;
        w_hit_nxt         = 1'b0;
        w_miss_nxt        = 1'b0;
        w_last_player_nxt = r_last_player;
        w_lockout_nxt     = r_lockout;
        if (bus.enable) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_scores_nxt    = '0;
                        w_time_left_nxt = LP_SECS;
                        w_lockout_nxt   = '0;
                        w_state_nxt     = S_DRAW;
                    end
                end
                S_DRAW: w_state_nxt = S_FETCH;
                S_FETCH: begin
                    w_cur_val_nxt = bus.rand_val;
                    w_lockout_nxt = '0;
                    w_state_nxt   = S_PLAY;
                end
                S_PLAY: begin
                    if (w_any) begin
                        w_last_player_nxt = w_sel;
                        if (w_is_hit) begin
                            w_hit_nxt   = 1'b1;
                            w_state_nxt = S_DRAW;
                            for (int i = 0; i < NUM_PLAYERS; i++) begin
                                if (3'(i) == w_sel && r_scores[i*SCORE_W +: SCORE_W] < LP_SMAX)
                                    w_scores_nxt[i*SCORE_W +: SCORE_W] = r_scores[i*SCORE_W +: SCORE_W] + 1'b1;
                            end
                        end else begin
                            w_miss_nxt = 1'b1;
                            for (int i = 0; i < NUM_PLAYERS; i++) begin
                                if (3'(i) == w_sel)
                                    w_lockout_nxt[i] = 1'b1;
                            end
                            // Everyone has missed this number: skip to a fresh draw.
                            if (&w_lockout_nxt)
                                w_state_nxt = S_DRAW;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            // Countdown is evaluated after load scoring so that expiry overrides any DRAW move.
            if ((r_state == S_DRAW || r_state == S_FETCH || r_state == S_PLAY) &&
                bus.sec_tick && r_time_left != 7'd0) begin
                w_time_left_nxt = r_time_left - 7'd1;
                if (r_time_left == 7'd1)
                    w_state_nxt = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cur_val     <= '0;
            r_scores      <= '0;
            r_time_left   <= '0;
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;
            r_last_player <= '0;
            r_lockout     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur_val     <= w_cur_val_nxt;
            r_scores      <= w_scores_nxt;
            r_time_left   <= w_time_left_nxt;
            r_hit         <= w_hit_nxt;
            r_miss        <= w_miss_nxt;
            r_last_player <= w_last_player_nxt;
            r_lockout     <= w_lockout_nxt;
        end
    end

    // Winner is the first index reaching the maximum; a zero maximum is always reported as a tie.
    always_comb begin
        w_max     = '0;
        w_win     = '0;
        w_top_cnt = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (r_scores[i*SCORE_W +: SCORE_W] > w_max) begin
                w_max = r_scores[i*SCORE_W +: SCORE_W];
                w_win = 3'(i);
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (r_scores[i*SCORE_W +: SCORE_W] == w_max)
                w_top_cnt = w_top_cnt + 4'd1;
        end
    end

    assign bus.rand_req    = (r_state == S_DRAW) && bus.enable;
    assign bus.cur_val     = r_cur_val;
    assign bus.scores      = r_scores;
    assign bus.time_left   = r_time_left;
    assign bus.hit         = r_hit;
    assign bus.miss        = r_miss;
    assign bus.last_player = r_last_player;
    assign bus.lockout     = r_lockout;
    assign bus.round_over  = (r_state == S_DONE);
    assign bus.winner      = (r_state == S_DONE) ? w_win : 3'd0;
    assign bus.tie         = (r_state == S_DONE) && (w_top_cnt > 4'd1 || w_max == '0);
endmodule

// File: tb/tb_math_round_ctrl.sv
// tb/tb_math_round_ctrl.sv - randomized self-checking bench for math_round_ctrl
module tb_math_round_ctrl;
    localparam int NP = 2, DW = 4, TGT = 15, RS = 30, SW = 7, SMAX = 99;
    localparam int P_IDLE = 0, P_DRAW = 1, P_FETCH = 2, P_PLAY = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    math_round_ctrl_if #(.NUM_PLAYERS(NP), .DATA_W(DW), .SCORE_W(SW)) bus();

    math_round_ctrl #(
        .NUM_PLAYERS(NP), .DATA_W(DW), .TARGET(TGT),
        .ROUND_SECS(RS), .SCORE_W(SW), .SCORE_MAX(SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference game state
    int m_phase, m_cur, m_tl, m_hit, m_miss, m_last;
    int m_sc[NP];
    bit m_lock[NP];
    int g[NP];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_cur = 0; m_tl = 0; m_hit = 0; m_miss = 0; m_last = 0;
        for (int p = 0; p < NP; p++) begin
            m_sc[p] = 0; m_lock[p] = 0;
        end
    endtask

    task automatic model_update(input bit en, input bit st, input bit tk,
                                input logic [NP-1:0] ld, input int rv);
        int old, who;
        bit all_locked;
        old = m_phase;
        m_hit = 0; m_miss = 0;
        if (!en) return;
        if (old == P_IDLE || old == P_DONE) begin
            if (st) begin
                for (int p = 0; p < NP; p++) begin m_sc[p] = 0; m_lock[p] = 0; end
                m_tl = RS;
                m_phase = P_DRAW;
            end
        end else if (old == P_DRAW) begin
            m_phase = P_FETCH;
        end else if (old == P_FETCH) begin
            m_cur = rv % (1 << DW);
            for (int p = 0; p < NP; p++) m_lock[p] = 0;
            m_phase = P_PLAY;
        end else begin
            who = -1;
            for (int p = 0; p < NP; p++)
                if (who < 0 && ld[p] && !m_lock[p]) who = p;
            if (who >= 0) begin
                m_last = who;
                if (m_cur + g[who] == TGT) begin
                    m_hit = 1;
                    if (m_sc[who] < SMAX) m_sc[who]++;
                    m_phase = P_DRAW;
                end else begin
                    m_miss = 1;
                    m_lock[who] = 1;
                    all_locked = 1;
                    for (int p = 0; p < NP; p++) if (!m_lock[p]) all_locked = 0;
                    if (all_locked) m_phase = P_DRAW;
                end
            end
        end
        if (old != P_IDLE && old != P_DONE && tk && m_tl > 0) begin
            m_tl--;
            if (m_tl == 0) m_phase = P_DONE;
        end
    endtask

    task automatic compare_all();
        int best, win, cnt;
        logic [NP-1:0] lk;
        best = -1; win = 0; cnt = 0;
        for (int p = 0; p < NP; p++) if (m_sc[p] > best) begin best = m_sc[p]; win = p; end
        for (int p = 0; p < NP; p++) if (m_sc[p] == best) cnt++;
        for (int p = 0; p < NP; p++) lk[p] = m_lock[p];
        check("cur_val", bus.cur_val, m_cur);
        for (int p = 0; p < NP; p++)
            check($sformatf("score%0d", p), bus.scores[p*SW +: SW], m_sc[p]);
        check("time_left", bus.time_left, m_tl);
        check("hit", bus.hit, m_hit);
        check("miss", bus.miss, m_miss);
        check("hit_miss_excl", bus.hit & bus.miss, 0);
        check("last_player", bus.last_player, m_last);
        check("lockout", bus.lockout, lk);
        check("round_over", bus.round_over, m_phase == P_DONE);
        check("winner", bus.winner, (m_phase == P_DONE) ? win : 0);
        check("tie", bus.tie, (m_phase == P_DONE) && (cnt > 1 || best == 0));
        check("rand_req", bus.rand_req, (m_phase == P_DRAW) && bus.enable);
    endtask

    task automatic step(input bit en, input bit st, input bit tk,
                        input logic [NP-1:0] ld, input int rv);
        bus.enable   = en;
        bus.start    = st;
        bus.sec_tick = tk;
        bus.load     = ld;
        bus.rand_val = DW'(rv);
        for (int p = 0; p < NP; p++) bus.guess[p*DW +: DW] = DW'(g[p]);
        @(posedge clk);
        model_update(en, st, tk, ld, rv);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    // Correct submission by player p, then ride DRAW/FETCH back into PLAY.
    task automatic play_hit(input int p);
        g[p] = TGT - m_cur;
        step(1, 0, 0, NP'(1 << p), $urandom_range(0, 15));
        step(1, 0, 0, '0, $urandom_range(0, 15));
        step(1, 0, 0, '0, $urandom_range(0, 15));
    endtask

    initial begin
        bus.enable = 0; bus.start = 0; bus.sec_tick = 0; bus.load = '0;
        bus.rand_val = '0; bus.guess = '0;
        for (int p = 0; p < NP; p++) g[p] = 0;
        rst = 1'b0;
        #7;
        do_reset();

        // Start a round with rand_val 6
        step(1, 1, 0, '0, 6);
        check("tp_req_draw", bus.rand_req, 1);
        step(1, 0, 0, '0, 6);
        check("tp_req_once", bus.rand_req, 0);
        step(1, 0, 0, '0, 6);
        check("tp_cur6", bus.cur_val, 6);
        check("tp_time30", bus.time_left, 30);

        // Player 0 hits 6+9
        g[0] = 9;
        step(1, 0, 0, 2'b01, 6);
        check("tp_hit", bus.hit, 1);
        check("tp_score0", bus.scores[SW-1:0], 1);
        check("tp_hit_req", bus.rand_req, 1);
        step(1, 0, 0, '0, 6);
        step(1, 0, 0, '0, 6);

        // Player 1 misses, is locked, then player 0 misses: all locked -> redraw
        g[1] = 4;
        step(1, 0, 0, 2'b10, 6);
        check("tp_miss", bus.miss, 1);
        check("tp_lock1", bus.lockout, 2'b10);
        g[1] = 9;
        step(1, 0, 0, 2'b10, 6);
        check("tp_locked_ignored", bus.hit, 0);
        g[0] = 3;
        step(1, 0, 0, 2'b01, 6);
        check("tp_all_locked_req", bus.rand_req, 1);
        step(1, 0, 0, '0, 6);
        step(1, 0, 0, '0, 6);

        // Simultaneous correct loads: lowest index only
        g[0] = 9; g[1] = 9;
        step(1, 0, 0, 2'b11, 6);
        check("tp_prio_score0", bus.scores[SW-1:0], 2);
        check("tp_prio_score1", bus.scores[2*SW-1:SW], 0);
        step(1, 0, 0, '0, 6);
        step(1, 0, 0, '0, 6);

        // Build {3,2}, run clock down to 1, final hit by player 1 on the expiring tick
        play_hit(0);
        play_hit(1);
        play_hit(1);
        for (int i = 0; i < RS - 1; i++) step(1, 0, 1, '0, $urandom_range(0, 15));
        check("tp_time1", bus.time_left, 1);
        g[1] = TGT - m_cur;
        step(1, 0, 1, 2'b10, 5);
        check("tp_done", bus.round_over, 1);
        check("tp_tie", bus.tie, 1);
        check("tp_winner", bus.winner, 0);
        check("tp_no_req", bus.rand_req, 0);
        check("tp_final_score1", bus.scores[2*SW-1:SW], 3);

        // Restart from DONE
        step(1, 1, 0, '0, 7);
        check("tp_restart_score", bus.scores, 0);
        check("tp_restart_time", bus.time_left, RS);
        step(1, 0, 0, '0, 7);
        step(1, 0, 0, '0, 7);

        // Freeze while disabled
        g[0] = TGT - m_cur;
        for (int i = 0; i < 4; i++) step(0, 1, 1, 2'b01, 3);
        check("tp_freeze_time", bus.time_left, RS);
        check("tp_freeze_score", bus.scores[SW-1:0], 0);
        play_hit(0);

        // Saturation at SCORE_MAX
        for (int i = 0; i < SMAX + 5; i++) play_hit(0);
        check("tp_saturate", bus.scores[SW-1:0], SMAX);

        // Reset mid-round
        do_reset();

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            bit en, st, tk;
            logic [NP-1:0] ld;
            en = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 15) == 0);
            tk = ($urandom_range(0, 7) == 0);
            ld = ($urandom_range(0, 1) == 0) ? '0 : NP'($urandom);
            for (int p = 0; p < NP; p++)
                g[p] = ($urandom_range(0, 1) == 0) ? (TGT - m_cur) : $urandom_range(0, 15);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(en, st, tk, ld, $urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
